fir_mac_sequencer: RTL and testbench

- Time-multiplexed FIR engine: one signed N x 8 multiply-accumulate unit shared across all TAPS coefficients, stepped one tap per clock.
- Takes the place of a chain of per-tap delay/multiply/add stages where area matters more than throughput.
- Owns the sample delay line, the coefficient register file and the MAC schedule.
- Valid/ready handshake on both the sample input and the result output.

---
 rtl/fir_mac_sequencer.sv | 104 ++++++++++
 tb/tb_fir_mac_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one shared signed N x 8 multiply-accumulate unit
// steps through TAPS coefficients, one tap per clock, with valid/ready on both ends.
module fir_mac_sequencer #(
  parameter int N    = 16,
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic signed [7:0]     coef_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [N-1:0]   x_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*N-1:0] y_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  state_t                state, state_next;
  logic signed [N-1:0]   x_line [TAPS];
  logic signed [7:0]     coef   [TAPS];
  logic signed [2*N-1:0] acc, y_reg;
  logic [AW-1:0]         k;

  logic                  last_tap, accept, coef_write;
  logic signed [N+7:0]   prod;
  logic signed [2*N-1:0] prod_ext, acc_next;

  assign last_tap   = (k == LAST_TAP);
  assign accept     = (state == IDLE) && in_valid;
  assign coef_write = (state == IDLE) && coef_we && (int'(coef_addr) < TAPS);
  assign prod       = x_line[k] * coef[k];
  assign prod_ext   = (2*N)'(prod);
  assign acc_next   = acc + prod_ext;
  assign y_out      = y_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (last_tap) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result is latched separately from acc so it survives the next accept,
  // which clears acc before the following MAC pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      y_reg <= '0;
      k     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_line[i] <= '0;
        coef[i]   <= '0;
      end
    end else begin
      if (coef_write) begin
        coef[coef_addr] <= coef_data;
      end
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) begin
          x_line[i] <= x_line[i-1];
        end
        x_line[0] <= x_in;
        acc       <= '0;
        k         <= '0;
      end else if (state == MAC) begin
        acc <= acc_next;
        k   <= last_tap ? '0 : k + 1'b1;
        if (last_tap) y_reg <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: reset, impulse response, signed extremes,
// backpressure, coefficient write gating and reset during a MAC pass.
module tb_fir_mac_sequencer;

  localparam int N    = 16;
  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  coef_we;
  logic [AW-1:0]         coef_addr;
  logic signed [7:0]     coef_data;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [N-1:0]   x_in;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [2*N-1:0] y_out;
  logic                  busy;

  int total = 0;
  int bad   = 0;
  int n;
  logic signed [2*N-1:0] y, y_hold;

  fir_mac_sequencer #(.N(N), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic wait_ready();
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_output("in_ready_wait", 64'(in_ready), 1);
  endtask

  task automatic write_coef(input logic [AW-1:0] addr, input logic signed [7:0] data);
    wait_ready();
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic wait_result(output logic signed [2*N-1:0] result);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check_output("out_valid_wait", 64'(out_valid), 1);
    result = y_out;
  endtask

  // Accept one sample (optionally with a coefficient write on the same edge),
  // collect its result and complete the output handshake with out_ready high.
  task automatic send_sample(input logic signed [N-1:0] x, input logic we,
                             input logic [AW-1:0] addr, input logic signed [7:0] data,
                             output logic signed [2*N-1:0] result);
    wait_ready();
    x_in      = x;
    in_valid  = 1'b1;
    coef_we   = we;
    coef_addr = addr;
    coef_data = data;
    tick();
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    wait_result(result);
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;
    #2;

    // Reset values, checked while rst is still low and after release.
    rst = 1'b0;
    #1;
    check_output("rst_in_ready", 64'(in_ready), 1);
    check_output("rst_out_valid", 64'(out_valid), 0);
    check_output("rst_busy", 64'(busy), 0);
    check_output("rst_y_out", $signed(y_out), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check_output("post_rst_in_ready", 64'(in_ready), 1);
    check_output("post_rst_busy", 64'(busy), 0);
    send_sample(16'sd1000, 1'b0, '0, '0, y);
    check_output("no_coef_result", $signed(y), 0);

    // Impulse response with b[k] = k+1.
    apply_reset();
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 8'(i + 1));
    for (int i = 0; i < TAPS; i++) begin
      send_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, '0, '0, y);
      check_output($sformatf("impulse_%0d", i), $signed(y), i + 1);
    end
    send_sample(16'sd0, 1'b0, '0, '0, y);
    check_output("impulse_flushed", $signed(y), 0);

    // Coefficient write during MAC must be ignored.
    wait_ready();
    x_in     = 16'sd1;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    check_output("gate_busy", 64'(busy), 1);
    coef_we   = 1'b1;
    coef_addr = 3'd2;
    coef_data = 8'sd50;
    tick();
    tick();
    coef_we = 1'b0;
    wait_result(y);
    tick();
    check_output("gate_tap0", $signed(y), 1);
    send_sample(16'sd0, 1'b0, '0, '0, y);
    check_output("gate_tap1", $signed(y), 2);
    send_sample(16'sd0, 1'b0, '0, '0, y);
    check_output("gate_b2_unchanged", $signed(y), 3);
    // Write on the same edge as accept is used for that sample.
    send_sample(16'sd0, 1'b1, 3'd3, 8'sd77, y);
    check_output("same_edge_write", $signed(y), 77);

    // Latency and backpressure: b[0]=2, b[1]=1.
    apply_reset();
    write_coef(3'd0, 8'sd2);
    write_coef(3'd1, 8'sd1);
    out_ready = 1'b0;
    wait_ready();
    x_in     = 16'sd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check_output("busy_cycles", n, TAPS);
    check_output("valid_after_mac", 64'(out_valid), 1);
    check_output("bp_result", $signed(y_out), 20);
    y_hold = y_out;
    for (int i = 0; i < 5; i++) begin
      x_in     = 16'sd99;
      in_valid = (i % 2 == 0);
      tick();
      check_output("bp_y_stable", $signed(y_out), $signed(y_hold));
      check_output("bp_in_ready_low", 64'(in_ready), 0);
      check_output("bp_valid_held", 64'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_output("bp_in_ready_back", 64'(in_ready), 1);
    check_output("bp_valid_dropped", 64'(out_valid), 0);
    check_output("y_kept_after_hs", $signed(y_out), 20);
    send_sample(16'sd3, 1'b0, '0, '0, y);
    check_output("bp_extra_ignored", $signed(y), 16);

    // Signed extremes.
    apply_reset();
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), -8'sd128);
    for (int i = 0; i < TAPS; i++) begin
      send_sample(-16'sd32768, 1'b0, '0, '0, y);
      check_output($sformatf("extreme_%0d", i), $signed(y), (i + 1) * 4194304);
    end
    check_output("extreme_final", $signed(y), 33554432);
    apply_reset();
    write_coef(3'd0, -8'sd128);
    send_sample(16'sd32767, 1'b0, '0, '0, y);
    check_output("max_pos_x", $signed(y), -4194176);

    // Reset in the middle of a MAC pass.
    wait_ready();
    x_in     = 16'sd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_output("mid_mac_busy", 64'(busy), 1);
    rst = 1'b0;
    #1;
    check_output("mid_rst_busy", 64'(busy), 0);
    check_output("mid_rst_in_ready", 64'(in_ready), 1);
    check_output("mid_rst_y_out", $signed(y_out), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("mid_rst_no_valid", 64'(out_valid), 0);
    end
    rst = 1'b1;
    tick();
    check_output("after_rst_no_valid", 64'(out_valid), 0);
    send_sample(16'sd7, 1'b0, '0, '0, y);
    check_output("after_rst_coefs_zero", $signed(y), 0);
    write_coef(3'd1, 8'sd1);
    send_sample(16'sd9, 1'b0, '0, '0, y);
    check_output("after_rst_history", $signed(y), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
